sfu_ctrl: RTL

SFU_CTRL -- requirements
Module: sfu_ctrl

---
 rtl/sfu_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sfu_ctrl.sv
// sfu_ctrl -- sequencer between the output FIFO, the SFU lanes and the psum memory.
//
// Weight-stationary (mode 0): for each output vector, wait until the ofifo
// holds a full run of num_pass beats, pop and accumulate them back to back,
// let the SFU pipeline drain for two cycles, then write psum_out once.
// Output-stationary (mode 1): the array already produced finished sums, so
// every popped entry is written straight through one cycle after its pop.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start_i           job start pulse (only looked at in IDLE)
//   mode_i            1 = output-stationary, 0 = weight-stationary
//   num_pass_i        beats per output vector in W.S (0 behaves as 1)
//   num_out_i         output vectors in the job (0 = empty job)
//   base_addr_i       first psum write address
//   ofifo_cnt_i       current ofifo occupancy
//   ofifo_rd_o        ofifo pop (show-ahead data)
//   sfu_acc_o         SFU accumulate enable
//   sfu_mode_o        SFU mode select (captured mode)
//   pmem_wen_o        psum memory write enable
//   pmem_addr_o       psum memory write address
//   busy_o            high outside IDLE
//   done_o            one-cycle job completion pulse
//   state_o           current FSM state (debug visibility)
//
// Handshake: ofifo_rd_o is a pop request that is only raised when the entry is
// known to be present at the moment of the pop; there is no back-pressure from
// the SFU or the psum memory, both accept one item per cycle unconditionally.
module sfu_ctrl #(
    parameter int col     = 8,
    parameter int addr_bw = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [7:0]         num_pass_i,
    input  logic [addr_bw-1:0] num_out_i,
    input  logic [addr_bw-1:0] base_addr_i,
    input  logic [7:0]         ofifo_cnt_i,
    output logic               ofifo_rd_o,
    output logic               sfu_acc_o,
    output logic               sfu_mode_o,
    output logic               pmem_wen_o,
    output logic [addr_bw-1:0] pmem_addr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2:0]         state_o
);

    if (col < 1) begin : g_col_check
        $error("sfu_ctrl: col must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WS_ACC   = 3'd1,
        WS_WAIT  = 3'd2,
        WS_WR    = 3'd3,
        OS_RUN   = 3'd4,
        OS_FLUSH = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [addr_bw-1:0] one_a = {{(addr_bw-1){1'b0}}, 1'b1};

    state_t             state;
    logic [7:0]         npass_q;   // beats per vector, never 0
    logic [addr_bw-1:0] nout_q;
    logic [addr_bw-1:0] addr_q;    // address of the current / next write
    logic [addr_bw-1:0] cnt_q;     // W.S: vectors written, O.S: pops issued
    logic [7:0]         beat_q;    // beats issued in the current W.S run
    logic               wait_q;    // second W.S drain cycle
    logic               os_avail;

    assign state_o     = state;
    assign pmem_addr_o = addr_q;

    // Outputs are registered, so the decision made at this edge becomes a pop
    // in the next cycle. If a pop is in flight right now the ofifo will lose
    // one entry at this edge, so at least two must be present to pop again.
    assign os_avail = ofifo_rd_o ? (ofifo_cnt_i > 8'd1) : (ofifo_cnt_i != 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            npass_q    <= '0;
            nout_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            wait_q     <= 1'b0;
            ofifo_rd_o <= 1'b0;
            sfu_acc_o  <= 1'b0;
            sfu_mode_o <= 1'b0;
            pmem_wen_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sfu_mode_o <= mode_i;
                        npass_q    <= (num_pass_i == 8'd0) ? 8'd1 : num_pass_i;
                        nout_q     <= num_out_i;
                        addr_q     <= base_addr_i;
                        cnt_q      <= '0;
                        beat_q     <= '0;
                        wait_q     <= 1'b0;
                        busy_o     <= 1'b1;
                        if (num_out_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (mode_i) begin
                            state <= OS_RUN;
                        end else begin
                            state <= WS_ACC;
                        end
                    end
                end

                WS_ACC: begin
                    // A run is only started when all of its beats are already
                    // buffered, so it can never stall half way through.
                    if (!ofifo_rd_o) begin
                        if (ofifo_cnt_i >= npass_q) begin
                            ofifo_rd_o <= 1'b1;
                            sfu_acc_o  <= 1'b1;
                            beat_q     <= 8'd1;
                        end
                    end else if (beat_q == npass_q) begin
                        ofifo_rd_o <= 1'b0;
                        sfu_acc_o  <= 1'b0;
                        wait_q     <= 1'b0;
                        state      <= WS_WAIT;
                    end else begin
                        beat_q <= beat_q + 8'd1;
                    end
                end

                WS_WAIT: begin
                    // Two cycles for the SFU accumulator to settle.
                    if (wait_q) begin
                        pmem_wen_o <= 1'b1;
                        state      <= WS_WR;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end

                WS_WR: begin
                    pmem_wen_o <= 1'b0;
                    addr_q     <= addr_q + one_a;
                    cnt_q      <= cnt_q + one_a;
                    if (cnt_q + one_a == nout_q) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= WS_ACC;
                    end
                end

                OS_RUN: begin
                    // Each pop turns into a write on the following cycle.
                    pmem_wen_o <= ofifo_rd_o;
                    if (pmem_wen_o) begin
                        addr_q <= addr_q + one_a;
                    end
                    if (cnt_q == nout_q) begin
                        ofifo_rd_o <= 1'b0;
                        state      <= OS_FLUSH;
                    end else if (os_avail) begin
                        ofifo_rd_o <= 1'b1;
                        cnt_q      <= cnt_q + one_a;
                    end else begin
                        ofifo_rd_o <= 1'b0;
                    end
                end

                OS_FLUSH: begin
                    pmem_wen_o <= 1'b0;
                    addr_q     <= addr_q + one_a;
                    done_o     <= 1'b1;
                    state      <= DONE;
                end

                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    ofifo_rd_o <= 1'b0;
                    sfu_acc_o  <= 1'b0;
                    pmem_wen_o <= 1'b0;
                    done_o     <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
